// File: rtl/lsu_mem_master_if.sv
// Word-wide data memory bus between the load/store unit (master) and the
// data memory (slave); read data returns one cycle after the address.
interface lsu_mem_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] memReadData;

  modport master (
    output memAddr,
    output memWriteData,
    output MemWrite,
    output MemRead,
    input  memReadData
  );

  modport slave (
    input  memAddr,
    input  memWriteData,
    input  MemWrite,
    input  MemRead,
    output memReadData
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: byte/halfword/word CPU accesses onto a word memory,
// using read-modify-write for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_mem_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  lsu_mem_master_if.master  mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sign_ext_q, sign_ext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              misalign;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;

  // Only the trap build looks at the low address bits for alignment.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    byte_lane = mem.memReadData[{addr_q[1:0], 3'b000} +: 8];
    half_lane = mem.memReadData[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{(DATA_W-8){sign_ext_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{(DATA_W-16){sign_ext_q & half_lane[15]}}, half_lane};
      default: load_val = mem.memReadData;
    endcase
  end

  always_comb begin
    merged = mem.memReadData;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          sign_ext_d = sign_ext;
          addr_d     = addr;
          wdata_d    = wdata;
          err_d      = misalign;
          if (misalign)
            state_d = S_DONE;
          else if (we && size[1])
            state_d = S_WR;
          else
            state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (we_q) begin
          state_d = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mem_read_d  = (state_d == S_RD_DATA);
    mem_write_d = (state_d == S_WR);
    mem_addr_d  = '0;
    if ((state_d == S_RD_ADDR) || (state_d == S_RD_DATA) || (state_d == S_WR))
      mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
    mem_wdata_d = '0;
    if (state_d == S_WR)
      mem_wdata_d = (state_q == S_IDLE) ? wdata : merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sign_ext_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sign_ext_q  <= sign_ext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign rdata            = rdata_q;
  assign mem.MemRead      = mem_read_q;
  assign mem.MemWrite     = mem_write_q;
  assign mem.memAddr      = mem_addr_q;
  assign mem.memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master: a word memory model, a per-cycle
// expectation queue built from the access rules, and directed literal checks.
module tb_lsu_mem_master;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  lsu_mem_master_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .mem      (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: registered read of the addressed word every edge, gated by MemRead.
  logic [31:0] dmem [0:63];
  logic [31:0] mem_rd_q;
  always @(posedge clk) begin
    mem_rd_q <= dmem[mem_bus.memAddr[7:2]];
    if (mem_bus.MemWrite)
      dmem[mem_bus.memAddr[7:2]] <= mem_bus.memWriteData;
  end
  assign mem_bus.memReadData = mem_bus.MemRead ? mem_rd_q : 32'h0;

  typedef struct {
    logic        busy;
    logic        done;
    logic        rd;
    logic        wr;
    logic        chk_addr;
    logic        chk_err;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] ref_mem [0:63];
  logic [31:0] model_rdata;
  int          checks;
  int          errors;
  bit          cmp_off;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] sz,
                                              input logic sx, input logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (word >> (8 * a[1:0])) & 32'h0000_00FF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (word >> (16 * a[1])) & 32'h0000_FFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    if (sz[1]) return wd;
    sh   = (sz == 2'b00) ? 8 * a[1:0] : 16 * a[1];
    mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (word & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  // Drives one request, waits for the accept edge, then queues the expected
  // outputs for every cycle until done. Returns at accept+#1.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sx,
                               input logic [31:0] a, input logic [31:0] wd,
                               input bit hold, input bit commit, output int lat);
    exp_t        e;
    logic        mis;
    logic [31:0] word;
    logic [31:0] prev;
    logic [31:0] nw;
    we = st; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    mis  = is_misaligned(sz, a);
    word = ref_mem[a[7:2]];
    prev = model_rdata;
    nw   = merge_store(word, sz, a, wd);
    if (mis)              lat = 1;
    else if (st && sz[1]) lat = 2;
    else if (!st)         lat = 3;
    else                  lat = 4;
    for (int k = 1; k <= lat; k++) begin
      e.busy = 1'b1; e.done = 1'b0; e.rd = 1'b0; e.wr = 1'b0;
      e.chk_addr = 1'b0; e.chk_err = 1'b0; e.err = 1'b0;
      e.addr = {a[31:2], 2'b00}; e.wdata = 32'h0; e.rdata = prev;
      if (k == lat) begin
        e.done = 1'b1; e.chk_err = 1'b1; e.err = mis;
        if (!st && !mis) e.rdata = extend_load(word, sz, sx, a);
      end else begin
        e.chk_addr = 1'b1;
        if (st && (k == lat - 1)) begin
          e.wr = 1'b1; e.wdata = nw;
        end else if (k == 2) begin
          e.rd = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
    if (!mis && !st) model_rdata = extend_load(word, sz, sx, a);
    if (!mis && st && commit) ref_mem[a[7:2]] = nw;
    #1;
    if (hold) begin
      req = 1'b1; we = 1'($urandom_range(1, 0)); size = 2'($urandom_range(3, 0));
      sign_ext = 1'($urandom_range(1, 0)); addr = $urandom; wdata = $urandom;
    end else begin
      req = 1'b0;
    end
  endtask

  task automatic doAccess(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold);
    int lat;
    applyStimulus(st, sz, sx, a, wd, hold, 1'b1, lat);
    repeat (lat) @(posedge clk);
    #2 req = 1'b0;
  endtask

  // Single compare process: every cycle checks the DUT against the next queued expectation.
  always @(negedge clk) begin
    if (!cmp_off) begin
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
      end else begin
        cur.busy = 1'b0; cur.done = 1'b0; cur.rd = 1'b0; cur.wr = 1'b0;
        cur.chk_addr = 1'b0; cur.chk_err = 1'b0; cur.err = 1'b0;
        cur.addr = 32'h0; cur.wdata = 32'h0; cur.rdata = model_rdata;
      end
      checkOutput("busy", 32'(busy), 32'(cur.busy));
      checkOutput("done", 32'(done), 32'(cur.done));
      checkOutput("MemRead", 32'(mem_bus.MemRead), 32'(cur.rd));
      checkOutput("MemWrite", 32'(mem_bus.MemWrite), 32'(cur.wr));
      checkOutput("memWriteData", mem_bus.memWriteData, cur.wdata);
      checkOutput("rdata", rdata, cur.rdata);
      if (cur.chk_addr) checkOutput("memAddr", mem_bus.memAddr, cur.addr);
      if (cur.chk_err)  checkOutput("err", 32'(err), 32'(cur.err));
    end
  end

  initial begin
    int lat;
    int gap;
    checks = 0; errors = 0; cmp_off = 1'b1; model_rdata = 32'h0;
    req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 64; i++) dmem[i] = $urandom;
    dmem[4]  = 32'h0;
    dmem[8]  = 32'h1122_3344;
    dmem[12] = 32'h8000_F0FF;
    for (int i = 0; i < 64; i++) ref_mem[i] = dmem[i];

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    cmp_off = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_memAddr", mem_bus.memAddr, 32'h0);
    checkOutput("reset_strobes", 32'({mem_bus.MemRead, mem_bus.MemWrite}), 32'h0);

    doAccess(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    checkOutput("sw_mem", dmem[4], 32'hDEAD_BEEF);
    doAccess(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    checkOutput("lw_rdata", rdata, 32'hDEAD_BEEF);
    doAccess(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 1'b0);
    checkOutput("sb_mem", dmem[8], 32'h11AA_3344);
    doAccess(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 1'b0);
    checkOutput("lb", rdata, 32'hFFFF_FFFF);
    doAccess(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1'b0);
    checkOutput("lbu", rdata, 32'h0000_00F0);
    doAccess(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0);
    checkOutput("lh", rdata, 32'hFFFF_8000);
    doAccess(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0);
    checkOutput("lhu", rdata, 32'h0000_8000);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("mis_done", 32'({done, err}), 32'h3);
    repeat (lat) @(posedge clk);
    #2 req = 1'b0;
    checkOutput("mis_rdata", rdata, 32'h0000_8000);
`else
    repeat (lat) @(posedge clk);
    #2 req = 1'b0;
    checkOutput("mis_rdata", rdata, 32'hDEAD_BEEF);
`endif

    doAccess(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);
    checkOutput("hold_rdata", rdata, 32'h8000_F0FF);

    // Reset during RD_DATA of a byte store must abandon the write.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0055, 1'b0, 1'b0, lat);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    model_rdata = 32'h0;
    #2 reset = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_memAddr", mem_bus.memAddr, 32'h0);
    checkOutput("rst_strobes", 32'({mem_bus.MemRead, mem_bus.MemWrite, done, err}), 32'h0);
    @(posedge clk);
    #2;
    checkOutput("rst_mem", dmem[8], 32'h11AA_3344);

    for (int n = 0; n < 300; n++) begin
      doAccess(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
               32'($urandom_range(255, 0)), $urandom, ($urandom_range(3, 0) == 0));
      gap = $urandom_range(2, 0);
      repeat (gap) begin
        @(posedge clk);
        #2;
      end
    end

    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 64; i++) checkOutput("final_mem", dmem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator sitting between the MIPS datapath and the word-wide data memory.
- Converts CPU byte, halfword and word loads/stores into word accesses on the memory's MemRead/MemWrite/memAddr interface.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Holds the pipeline through busy and reports completion with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, byte-address width on the CPU and memory sides.
- DATA_W, 32, word width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  CPU access request; sampled only in IDLE
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  input  32  byte address
- wdata  input  32  store data, right-justified
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- rdata  output  32  extended load result, valid when done=1
- err  output  1  misalignment flag, valid when done=1
- memAddr  output  32  word-aligned byte address {addr[31:2],2'b00}
- memWriteData  output  32  merged write word; 0 unless MemWrite
- MemWrite  output  1  memory write strobe
- MemRead  output  1  memory read-data enable
- memReadData  input  32  memory read word; registered inside memory with 1-cycle latency, gated to 0 when MemRead=0

Behaviour:
- Reset:
  - State = IDLE.
  - busy, done, err, MemWrite, MemRead = 0.
  - rdata, memAddr, memWriteData = 0.
  - Reset mid-operation abandons the access; no MemWrite is issued afterward.
- Memory timing contract:
  - The memory captures dataMemory[memAddr>>2] at every rising edge.
  - Read data is sampled in the following cycle with MemRead=1.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. Halfword lane = addr[1].
- Accept: in IDLE with req=1, latch we, size, sign_ext, addr and wdata at the edge.
- State sequence after accept:
  - Store word -> WR.
  - Anything else -> RD_ADDR.
  - Misaligned access (see Optional Feature) -> DONE with err=1, no memory cycle.
- States:
  - RD_ADDR: drive memAddr; MemRead=0, MemWrite=0. Next state RD_DATA.
  - RD_DATA: drive memAddr, MemRead=1, capture memReadData.
    - Load: extract the lane, extend to 32 bits, register into rdata, go to DONE.
    - Sub-word store: replace the target lane(s) with wdata[7:0] or wdata[15:0], keep the other lanes, go to WR.
  - WR: MemWrite=1, memWriteData = merged word (or wdata for a word store), memAddr driven. Next state DONE.
  - DONE: done=1 for exactly one cycle; rdata and err held. Next state IDLE.
  - IDLE: busy=0. rdata retains its last value until the next load completes.
- Latency from the accept edge to the done cycle:
  - Store word: 2.
  - Load (any size): 3.
  - Byte/halfword store: 4.
  - Misaligned access: 1.
- Request handling:
  - req is ignored while busy.
  - A new request is accepted only in IDLE, so back-to-back throughput is one access every latency+1 cycles.
- Store results: rdata is unchanged on stores; err=0 except on misalignment.
- Strobe exclusivity: MemRead and MemWrite are never high in the same cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, goes to DONE with err=1.
  - No memory access occurs; rdata is unchanged.
- Undefined:
  - err is tied to 0.
  - Low misaligned bits are ignored: halfword uses addr[1]; word forces 00.
  - The access proceeds normally.

Test Plan:
- Word store/load:
  - req, we=1, size=10, addr=0x10, wdata=0xDEADBEEF -> MemWrite=1 at accept+1 with memAddr=0x10, done at accept+2.
  - Then load word at 0x10 -> rdata=0xDEADBEEF, done at accept+3.
- Byte store read-modify-write: memory word at 0x20 = 0x11223344; sb addr=0x22, wdata=0x000000AA.
  - RD_ADDR -> RD_DATA -> WR writes 0x11AA3344.
  - MemRead and MemWrite are never coincident; done at accept+4.
- Extension, word 0x8000F0FF at 0x30:
  - lb addr=0x30 sign_ext=1 -> 0xFFFFFFFF.
  - lbu addr=0x31 -> 0x000000F0.
  - lh addr=0x32 sign_ext=1 -> 0xFFFF8000.
  - lhu addr=0x32 -> 0x00008000.
- Busy/ignore: assert req continuously during a load -> exactly one access per IDLE visit; busy high for 3 cycles; done pulse width 1.
- Reset mid-operation: assert reset in RD_DATA of a sb -> next cycle IDLE, all outputs 0, memory word unchanged.
- Misalignment:
  - With LSU_MISALIGN_TRAP_EN, lw addr=0x13 -> done at accept+1, err=1, no MemRead/MemWrite.
  - Without it, same access reads word 0x10, err=0.
